// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the program/data RAM port arbiter.
package mem_port_arbiter_pkg;

    localparam int NREQ_DEF      = 3;
    localparam int ADDR_W_DEF    = 8;
    localparam int DATA_W_DEF    = 16;
    localparam int MEM_DEPTH_DEF = 256;

    localparam int REQ_FETCH = 0;
    localparam int REQ_LOAD  = 1;
    localparam int REQ_WB    = 2;

    typedef logic [1:0] ArbState;
    localparam ArbState AIDLE  = 2'd0;
    localparam ArbState AISSUE = 2'd1;
    localparam ArbState ARESP  = 2'd2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after `last`, wrapping.
module mem_port_arbiter_rr_picker
    import mem_port_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] win
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        // Walk from farthest to nearest so the nearest requester after `last` wins.
        for (int i = NREQ; i >= 1; i--) begin
            cand = IDX_W'((int'(last) + i) % NREQ);
            if (req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-port program/data RAM between
// fetch, operand-load and writeback requesters; single-beat req/ack accesses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*DATA_W-1:0] wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        ack,
    output logic [DATA_W-1:0]      rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   busy,
    output logic                   err
);

    localparam int IDX_W = idx_width(NREQ);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    ArbState          state, state_nxt;
    logic [IDX_W-1:0] win, last, pick;
    logic             found, err_q, resp_rd;
    logic             issue, resp;
    logic [NREQ-1:0]  win_oh, pick_req;
    logic             sel_we, sel_oor;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign issue     = (state == AISSUE);
    assign resp      = (state == ARESP);
    assign win_oh    = NREQ'(1) << win;
    assign sel_we    = we[win];
    assign sel_addr  = addr[win*ADDR_W +: ADDR_W];
    assign sel_wdata = wdata[win*DATA_W +: DATA_W];
    assign sel_oor   = {1'b0, sel_addr} >= DEPTH_LIM;

    // The requester being acked may still hold req this cycle; it is not a new request yet.
    assign pick_req = resp ? (req & ~ack) : req;

    mem_port_arbiter_rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req   (pick_req),
        .last  (last),
        .found (found),
        .win   (pick)
    );

    always_comb begin
        state_nxt = AIDLE;
        case (state)
            AIDLE:   state_nxt = found ? AISSUE : AIDLE;
            AISSUE:  state_nxt = ARESP;
            ARESP:   state_nxt = found ? AISSUE : AIDLE;
            default: state_nxt = AIDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= AIDLE;
            win     <= '0;
            last    <= IDX_W'(NREQ - 1);
            err_q   <= 1'b0;
            resp_rd <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == AISSUE) win <= pick;
            if (issue) begin
                last    <= win;
                // Capture the access kind now so late input changes cannot disturb rdata.
                resp_rd <= ~sel_we & ~sel_oor;
                if (sel_oor) err_q <= 1'b1;
            end
        end
    end

    assign gnt       = issue ? win_oh : '0;
    assign ack       = resp ? win_oh : '0;
    assign mem_en    = issue & ~sel_oor;
    assign mem_we    = issue & ~sel_oor & sel_we;
    assign mem_addr  = issue ? sel_addr : '0;
    assign mem_wdata = issue ? sel_wdata : '0;
    assign rdata     = (resp & resp_rd) ? mem_rdata : '0;
    assign busy      = (state != AIDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: RAM model, ack scoreboard and step checks.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int NREQ      = 3;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 128;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ-1:0]        we = '0;
    logic [NREQ*ADDR_W-1:0] addr = '0;
    logic [NREQ*DATA_W-1:0] wdata = '0;
    logic [NREQ-1:0]        gnt, ack;
    logic [DATA_W-1:0]      rdata;
    logic                   mem_en, mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata = '0;
    logic                   busy, err;

    mem_port_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int                idx;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   glog[$];
    int   gcyc[$];
    int   busy_cnt;
    logic exp_err = 1'b0;

    // RAM macro model with 1-cycle read latency and a backdoor preload port.
    logic [DATA_W-1:0] ram [256];
    logic              bd_en = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [DATA_W-1:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_en) ram[bd_addr] <= bd_data;
        else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    // Scoreboard: every ack pops the oldest expected response.
    always @(negedge clk) begin
        if (ack !== '0) begin
            if (sb.size() == 0) check("sb_spurious_ack", 32'(ack), 32'd0);
            else begin
                mon_e = sb.pop_front();
                check("sb_ack", 32'(ack), 32'(1) << mon_e.idx);
                check("sb_rdata", 32'(rdata), 32'(mon_e.data));
            end
        end
    end

    function automatic int oh2idx(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(gnt), 0);
        check({tag, "_ack"},   32'(ack), 0);
        check({tag, "_rdata"}, 32'(rdata), 0);
        check({tag, "_memen"}, 32'({mem_en, mem_we}), 0);
        check({tag, "_maddr"}, 32'(mem_addr), 0);
        check({tag, "_mwdat"}, 32'(mem_wdata), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_err"},   32'(err), 0);
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bd_en = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_en = 1'b0;
    endtask

    task automatic set_req(input int idx, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        we[idx] = wr;
        addr[idx*ADDR_W +: ADDR_W] = a;
        wdata[idx*DATA_W +: DATA_W] = d;
        req[idx] = 1'b1;
    endtask

    // One isolated access from AIDLE, checked cycle by cycle.
    task automatic single_access(input int idx, input logic wr, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd,
                                 input logic oor);
        @(posedge clk); #1;
        set_req(idx, wr, a, d);
        sb.push_back('{idx, exp_rd});
        @(negedge clk);
        check("lat0_gnt", 32'(gnt), 0);
        @(negedge clk);
        check("issue_gnt",    32'(gnt), 32'(1) << idx);
        check("issue_busy",   32'(busy), 1);
        check("issue_mem_en", 32'(mem_en), 32'(!oor));
        check("issue_mem_we", 32'(mem_we), 32'(wr && !oor));
        check("issue_addr",   32'(mem_addr), 32'(a));
        if (wr) check("issue_wdata", 32'(mem_wdata), 32'(d));
        check("issue_err",    32'(err), 32'(exp_err));
        if (oor) exp_err = 1'b1;
        @(negedge clk);
        check("resp_ack",   32'(ack), 32'(1) << idx);
        check("resp_rdata", 32'(rdata), 32'(exp_rd));
        check("resp_gnt",   32'(gnt), 0);
        check("resp_err",   32'(err), 32'(exp_err));
        @(posedge clk); #1;
        req[idx] = 1'b0;
        @(negedge clk);
        check("post_idle", 32'(busy), 0);
    endtask

    // Runs until all requests are acked, dropping each req on the cycle after its ack.
    task automatic drain(input int budget);
        int n = 0;
        logic [NREQ-1:0] seen;
        busy_cnt = 0;
        glog.delete();
        gcyc.delete();
        while ((req != '0 || busy) && n < budget) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (gnt != '0) begin
                glog.push_back(oh2idx(gnt));
                gcyc.push_back(n);
            end
            seen = ack;
            @(posedge clk); #1;
            req = req & ~seen;
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check_all_zero("reset");
        preload(8'h10, 16'hBEEF);
        preload(8'h30, 16'hA000);
        preload(8'h31, 16'hA001);
        preload(8'h32, 16'hA002);
        rstn = 1'b1;

        // Contention: all three hold req; order 0,1,2 two cycles apart, busy for 6 cycles.
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b0, ADDR_W'(8'h30 + i), '0);
            sb.push_back('{i, DATA_W'(16'hA000 + i)});
        end
        drain(40);
        check("cont_ngrants", 32'(glog.size()), 3);
        check("cont_order0", 32'(glog[0]), 0);
        check("cont_order1", 32'(glog[1]), 1);
        check("cont_order2", 32'(glog[2]), 2);
        check("cont_gap01", 32'(gcyc[1] - gcyc[0]), 2);
        check("cont_gap12", 32'(gcyc[2] - gcyc[1]), 2);
        check("cont_busy", 32'(busy_cnt), 6);

        // Wrap: last granted was 2, so 0 beats 2, then 2 follows.
        @(posedge clk); #1;
        set_req(REQ_FETCH, 1'b0, 8'h30, '0);
        set_req(REQ_WB,    1'b0, 8'h32, '0);
        sb.push_back('{REQ_FETCH, 16'hA000});
        sb.push_back('{REQ_WB,    16'hA002});
        drain(40);
        check("wrap_ngrants", 32'(glog.size()), 2);
        check("wrap_first", 32'(glog[0]), REQ_FETCH);
        check("wrap_second", 32'(glog[1]), REQ_WB);

        single_access(REQ_FETCH, 1'b0, 8'h10, '0, 16'hBEEF, 1'b0);

        single_access(REQ_WB, 1'b1, 8'h20, 16'h1234, '0, 1'b0);
        check("ram_written", 32'(ram[8'h20]), 32'h1234);
        single_access(REQ_LOAD, 1'b0, 8'h20, '0, 16'h1234, 1'b0);

        // Out-of-range: mem_rdata still holds 0x1234 yet rdata must be 0; err stays sticky.
        single_access(REQ_FETCH, 1'b0, 8'h90, '0, '0, 1'b1);
        single_access(REQ_WB, 1'b1, 8'h85, 16'h5555, '0, 1'b1);
        check("oor_no_write", 32'(ram[8'h05] === 16'h5555), 0);
        single_access(REQ_LOAD, 1'b0, 8'h10, '0, 16'hBEEF, 1'b0);
        check("err_sticky", 32'(err), 1);

        // Reset during AISSUE: outputs clear at once and the access is never acked.
        @(posedge clk); #1;
        set_req(REQ_WB, 1'b0, 8'h30, '0);
        @(negedge clk);
        @(negedge clk);
        check("midrst_gnt", 32'(gnt), 32'(1) << REQ_WB);
        #1;
        rstn = 1'b0;
        req = '0;
        exp_err = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) begin
            @(negedge clk);
            check("midrst_no_ack", 32'(ack), 0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        single_access(REQ_LOAD, 1'b0, 8'h31, '0, 16'hA001, 1'b0);

        check("sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single-port program/data RAM between NREQ requesters (index 0 instruction fetch during SREAD, 1 operand load during SLOAD1/SLOAD2, 2 result writeback during SWRITE). Each access is a single beat with a req/ack handshake. Grants rotate round-robin. An out-of-range address raises a sticky error that drives the sequencer's `err` input. The block sits between the sequencer-driven datapath stages and the RAM macro, which has 1-cycle read latency.

## Interface
- NREQ, 3: number of requesters
- ADDR_W, 8: RAM address width
- DATA_W, 16: RAM data width
- MEM_DEPTH, 256: valid addresses are 0..MEM_DEPTH-1
- clk  input  1  clock, all state updates on rising edge
- rstn  input  1  reset, asynchronous, active-low
- req  input  NREQ  per-requester request, level, held until ack
- we  input  NREQ  per-requester write enable (1 write, 0 read)
- addr  input  NREQ*ADDR_W  per-requester address, slice i = requester i
- wdata  input  NREQ*DATA_W  per-requester write data
- gnt  output  NREQ  one-hot, high during ISSUE for the winner
- ack  output  NREQ  one-hot single-cycle pulse during RESP
- rdata  output  DATA_W  read data, valid only while ack is high, else 0
- mem_en, mem_we  output  1  RAM enable / write strobe
- mem_addr  output  ADDR_W  RAM address
- mem_wdata  output  DATA_W  RAM write data
- mem_rdata  input  DATA_W  RAM read data, valid the cycle after mem_en
- busy  output  1  high in ISSUE or RESP
- err  output  1  sticky address-range error

## Operation
- FSM states: AIDLE, AISSUE, ARESP (enum ArbState).
- **AIDLE**
  - If any req is set, the round-robin picker chooses a winner. Search starts at (last+1) mod NREQ.
  - Winner index is registered and the FSM goes to AISSUE. Otherwise it stays in AIDLE.
- **AISSUE**
  - gnt[win]=1.
  - mem_en=1, mem_we=we[win], mem_addr=addr slice, mem_wdata=wdata slice.
  - `last` is updated to win.
  - Next state is always ARESP.
- **ARESP**
  - ack[win]=1.
  - rdata=mem_rdata for a read, 0 for a write.
  - Requester i must drop req on the cycle after ack. If it does not, that is a new request.
  - Next-winner search uses req masked with ~ack. If the result is nonzero, go directly to AISSUE with the new winner. Otherwise go to AIDLE.
- Out-of-range address (addr >= MEM_DEPTH) in AISSUE:
  - mem_en and mem_we are forced to 0.
  - err is set and stays high until reset.
  - ack still pulses in ARESP with rdata=0.
  - Arbitration continues normally.
- Requester inputs (we, addr, wdata) must be stable from req rising until ack. Changes after AISSUE have no effect.
- req dropping during AISSUE: the access completes and ack still pulses.
- Reset value of `last` is NREQ-1, so requester 0 wins first.

## Timing
- Reset (asynchronous, any state): FSM=AIDLE, last=NREQ-1.
  - All outputs are 0: gnt, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, err.
  - A transaction in flight is abandoned; no ack is issued.
- Latency: req sampled high in AIDLE at edge N. gnt/mem_en are high in cycle N+1, ack in cycle N+2.
- Back-to-back throughput: one access per 2 cycles while other requesters are pending (ARESP→AISSUE).
- A write commits at the edge ending AISSUE.
- Fairness: a continuously requesting requester is granted within NREQ-1 other grants, i.e. within 2*NREQ cycles.
- All outputs are combinational from registered state (FSM, win, err) and the current inputs. There is no input→output path through the FSM in the same cycle except rdata←mem_rdata.

## Structure
- `params.svh` gains:
  - typedef enum ArbState {AIDLE, AISSUE, ARESP}
  - constants REQ_FETCH=0, REQ_LOAD=1, REQ_WB=2
  - MEM_DEPTH default
- Sub-module `rr_picker` (combinational): inputs req vector and last index; outputs found flag and winner index. Instantiated once, with req masked by ~ack in ARESP.
- Top contains the FSM, win/last registers, the output mux and err.

## Test plan
- Single read: req[0]=1, we=0, addr=0x10, RAM[0x10]=0xBEEF → gnt[0] in cycle 1, mem_addr=0x10, ack[0] with rdata=0xBEEF in cycle 2, then AIDLE.
- Contention: req=3'b111 held, each dropping after its ack → grant order 0,1,2. gnt pulses 2 cycles apart, busy continuously high for 6 cycles.
- Round-robin wrap: after granting 2, assert req[0] and req[2] together → 0 wins; next grant goes to 2.
- Write then read: req[2] we=1 addr=0x20 wdata=0x1234, then req[1] read 0x20 → ack[1] with rdata=0x1234.
- Range error with MEM_DEPTH=128: req[0] addr=0x90 → mem_en stays 0, ack[0] with rdata=0, err=1 and stays high through later valid accesses.
- Reset mid-access: rstn low during AISSUE → all outputs 0 immediately, no ack. After release, req[1] alone is granted first with 2-cycle latency.
